// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampled start detection and a small receive FIFO.
// Bytes leave on a valid/ready stream; framing errors and overruns pulse for one cycle.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             rx,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [AW:0]      level,
    output logic             frame_err,
    output logic             overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state_q;
    logic [1:0]       sync_q;
    logic             rs;
    logic [DIV_W-1:0] d_in;
    logic [DIV_W-1:0] d_q;
    logic [DIV_W-1:0] cnt_q;
    logic             cnt_zero;
    logic [2:0]       bit_q;
    logic [7:0]       shreg_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    assign d_in     = (div < DIV_W'(4)) ? DIV_W'(4) : div;
    assign rs       = sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Counters hold "cycles to sample minus one", so a load of N-1 samples N cycles on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= DIV_W'(4);
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rs) begin
                        d_q     <= d_in;
                        cnt_q   <= (d_in >> 1) - DIV_W'(1);
                        state_q <= START;
                    end
                end
                START: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end else if (rs) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= d_q - DIV_W'(1);
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end else begin
                        shreg_q <= {rs, shreg_q[7:1]};
                        cnt_q   <= d_q - DIV_W'(1);
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end else if (rs) begin
                        state_q <= IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BRK;
                    end
                end
                BRK: begin
                    if (rs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push = (state_q == STOP) && cnt_zero && rs;

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign level      = wr_ptr_q - rd_ptr_q;
    assign dout_valid = (level != '0);
    assign full       = (level == (AW+1)'(FIFO_DEPTH));
    assign pop        = dout_valid && dout_ready;
    assign wr_en      = push && (!full || pop);
    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    assign dout       = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= push && !wr_en;
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
            end
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames driven on rx, expected bytes queued,
// monitor pops and compares on each valid/ready handshake.
module tb_uart_rx_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] div;
    logic        rx;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  level;
    logic        frame_err;
    logic        overrun;

    int checks;
    int errors;
    int cyc;
    int fall_cyc;
    int rise_cyc;
    int ferr_n;
    int ovr_n;
    int ovr_base;
    logic prev_v;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .FIFO_DEPTH(4),
        .DIV_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .div       (div),
        .rx        (rx),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .level     (level),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int bp, input int stop_low);
        rx = 1'b0;
        fall_cyc = cyc;
        tick(bp);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(bp);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            tick(stop_low);
        end
        rx = 1'b1;
        tick(bp);
    endtask

    task automatic wait_drain(input string tag, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick(1);
        tick(2);
        chk(tag, 32'(exp_q.size()), 32'd0);
        chk({tag, "_lvl"}, 32'(level), 32'd0);
    endtask

    initial begin
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_err) ferr_n++;
            if (overrun) ovr_n++;
            if (dout_valid && !prev_v) rise_cyc = cyc;
            prev_v = dout_valid;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("sb_data", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        ferr_n = 0;
        ovr_n = 0;
        rise_cyc = -1;
        fall_cyc = 0;
        rst = 1'b1;
        rx = 1'b1;
        div = 16'd16;
        dout_ready = 1'b1;
        tick(3);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(5);

        // basic frame and latency
        exp_q.push_back(8'h55);
        send(8'h55, 16, 0);
        tick(5);
        chk("t1_lat", 32'(rise_cyc - fall_cyc), 32'd155);
        chk("t1_ferr", 32'(ferr_n), 32'd0);
        wait_drain("t1_drain", 20);

        // glitch rejection
        rx = 1'b0;
        tick(6);
        rx = 1'b1;
        tick(40);
        chk("t2_valid", 32'(dout_valid), 32'd0);
        chk("t2_ferr", 32'(ferr_n), 32'd0);
        exp_q.push_back(8'hC7);
        send(8'hC7, 16, 0);
        wait_drain("t2_drain", 20);

        // framing error then recovery
        send(8'hA3, 16, 40);
        tick(10);
        chk("t3_ferr", 32'(ferr_n), 32'd1);
        chk("t3_level", 32'(level), 32'd0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 16, 0);
        wait_drain("t3_drain", 20);

        // overrun with no consumer
        dout_ready = 1'b0;
        ovr_base = ovr_n;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send(8'(i), 16, 0);
        end
        tick(10);
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_ovr", 32'(ovr_n - ovr_base), 32'd1);
        dout_ready = 1'b1;
        wait_drain("t4_drain", 40);

        // push while full with a same-cycle pop
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h90 + 8'(i));
            send(8'h90 + 8'(i), 16, 0);
        end
        tick(4);
        chk("t5_full", 32'(level), 32'd4);
        ovr_base = ovr_n;
        exp_q.push_back(8'h5A);
        fork
            send(8'h5A, 16, 0);
            begin
                tick(154);
                dout_ready = 1'b1;
                tick(1);
                dout_ready = 1'b0;
            end
        join
        tick(4);
        chk("t5_ovr", 32'(ovr_n - ovr_base), 32'd0);
        chk("t5_level", 32'(level), 32'd4);
        dout_ready = 1'b1;
        wait_drain("t5_drain", 40);

        // divisor clamp, then reset mid-frame
        div = 16'd2;
        exp_q.push_back(8'hF0);
        send(8'hF0, 4, 0);
        wait_drain("t6_drain", 20);
        dout_ready = 1'b0;
        send(8'h11, 4, 0);
        tick(4);
        chk("t6_pre", 32'(level), 32'd1);
        rx = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("t6_rvalid", 32'(dout_valid), 32'd0);
        chk("t6_rlevel", 32'(level), 32'd0);
        rst = 1'b0;
        rx = 1'b1;
        tick(10);
        dout_ready = 1'b1;
        exp_q.push_back(8'h77);
        send(8'h77, 4, 0);
        wait_drain("t6_after", 20);
        chk("end_ferr", 32'(ferr_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
